piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 123 ++++++++++++
 tb/tb_piso_serializer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// ============================================================================
// Module   : piso_serializer
// Purpose  : Parallel-in / serial-out serializer with a valid/ready load side.
//            Accepts a WIDTH-bit word in IDLE and shifts it out MSB first,
//            one bit per clock, then issues a single-cycle done pulse.
// Option   : PISO_SERIALIZER_PARITY_EN adds an even-parity bit after the data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] d,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd2;
`endif
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             armed;
  logic             accept;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             parity;
`endif

  assign accept = load_valid && load_ready;

  // Next-state decode; the last data bit is the SHIFT cycle with cnt == 1
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt == CNT_W'(1)) begin
`ifdef PISO_SERIALIZER_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_DONE;
`endif
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      S_PARITY: state_nxt = S_DONE;
`endif
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Held low through reset so load_ready only rises on the first edge after release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // Shift register and bit counter: load on accept, shift/decrement while in SHIFT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= d;
      cnt   <= CNT_W'(WIDTH);
    end else if (state == S_SHIFT) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
      cnt   <= cnt - CNT_W'(1);
    end
  end

`ifdef PISO_SERIALIZER_PARITY_EN
  // Even parity of the captured word, frozen at accept time
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      parity <= 1'b0;
    else if (accept) parity <= ^d;
  end
`endif

  // Outputs decoded purely from registered state
  always_comb begin
    load_ready = armed && (state == S_IDLE);
    done       = (state == S_DONE);
    sout_valid = 1'b0;
    sout       = 1'b0;
    if (state == S_SHIFT) begin
      sout_valid = 1'b1;
      sout       = shreg[WIDTH-1];
    end
`ifdef PISO_SERIALIZER_PARITY_EN
    if (state == S_PARITY) begin
      sout_valid = 1'b1;
      sout       = parity;
    end
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// ============================================================================
// Module   : tb_piso_serializer
// Purpose  : Self-checking bench for piso_serializer (WIDTH = 8). Expected
//            serial bits are queued at each accept and popped as bits appear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] d = '0;
  logic         sout;
  logic         sout_valid;
  logic         done;

  typedef struct {
    logic [7:0] d;
    logic       par;
  } vec_t;

  vec_t vecs [8];
  logic exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   last_accept = 0;

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .d          (d),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  task automatic push_frame(input logic [7:0] val, input logic par);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(val[i]);
`ifdef PISO_SERIALIZER_PARITY_EN
    exp_q.push_back(par);
`else
    if (par === 1'bx) exp_q.push_back(1'b0);
`endif
  endtask

  // One full frame: accept, then every cycle until load_ready returns
  task automatic run_frame(input logic [7:0] val, input logic par,
                           input logic nxt_valid, input logic [7:0] nxt_d,
                           input bit chk_period);
    int waited;
    waited = 0;
    while (load_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (load_ready !== 1'b1) begin
      check("ready_timeout", {31'd0, load_ready}, 32'd1);
      return;
    end
    load_valid = 1'b1;
    d          = val;
    @(posedge clk);
    push_frame(val, par);
    #1;
    if (chk_period) check("accept_period", cycle - last_accept, FRAME + 2);
    last_accept = cycle;
    load_valid  = nxt_valid;
    d           = nxt_d;
    for (int c = 1; c <= FRAME + 1; c++) begin
      @(negedge clk);
      check("valid", sout_valid, (c <= FRAME));
      check("done", done, (c == FRAME + 1));
      check("ready_busy", load_ready, 0);
      if (sout_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("extra_bit", 1, 0);
        end else begin
          logic b;
          b = exp_q.pop_front();
          check("bit", sout, b);
        end
      end else begin
        check("sout_zero", sout, 0);
      end
    end
    @(negedge clk);
    check("ready_idle", load_ready, 1);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Accept A5, abort with reset after the third bit, confirm clean recovery
  task automatic reset_abort();
    logic [7:0] pat;
    pat        = 8'hA5;
    load_valid = 1'b1;
    d          = pat;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    d          = 8'h3C;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("abort_valid", sout_valid, 1);
      check("abort_bit", sout, pat[W-c]);
    end
    #2 reset = 1'b0;
    #1;
    check("abort_sout_valid", sout_valid, 0);
    check("abort_sout", sout, 0);
    check("abort_done", done, 0);
    check("abort_ready", load_ready, 0);
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    reset = 1'b1;
    #1 check("abort_ready_pre_edge", load_ready, 0);
    @(negedge clk);
    check("abort_ready_post_edge", load_ready, 1);
  endtask

  initial begin
    vecs[0] = '{d: 8'h0F, par: 1'b0};
    vecs[1] = '{d: 8'h07, par: 1'b1};
    vecs[2] = '{d: 8'h03, par: 1'b0};
    vecs[3] = '{d: 8'hA5, par: 1'b0};
    vecs[4] = '{d: 8'h01, par: 1'b1};
    vecs[5] = '{d: 8'hFE, par: 1'b1};
    vecs[6] = '{d: 8'h5A, par: 1'b0};
    vecs[7] = '{d: 8'h00, par: 1'b0};

    // Reset held with a word offered: everything stays quiet
    reset      = 1'b0;
    load_valid = 1'b1;
    d          = 8'hA5;
    repeat (3) @(negedge clk);
    check("rst_ready", load_ready, 0);
    check("rst_valid", sout_valid, 0);
    check("rst_sout", sout, 0);
    check("rst_done", done, 0);
    reset      = 1'b1;
    load_valid = 1'b0;
    #1 check("release_ready_pre_edge", load_ready, 0);
    @(negedge clk);
    check("release_ready_post_edge", load_ready, 1);

    // Table of single frames; d is scrambled while the frame is shifting
    for (int i = 0; i < 8; i++)
      run_frame(vecs[i].d, vecs[i].par, 1'b0, 8'($urandom), 1'b0);

    // New word offered during SHIFT is held off until the next IDLE
    run_frame(8'h5A, 1'b0, 1'b1, 8'hFF, 1'b0);
    run_frame(8'hFF, 1'b0, 1'b0, 8'h00, 1'b1);

    // load_valid held high: back-to-back frames at the minimum period
    run_frame(8'h81, 1'b0, 1'b1, 8'h81, 1'b0);
    run_frame(8'h81, 1'b0, 1'b1, 8'h81, 1'b1);
    run_frame(8'h81, 1'b0, 1'b0, 8'h00, 1'b1);

    // Mid-frame reset, then a clean frame
    reset_abort();
    run_frame(8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
